// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ requesters.
// Define MEM_ARB_BURST_EN to add the per-requester blen input for multi-beat grants.
module mem_access_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef MEM_ARB_BURST_EN
  input  logic [NUM_REQ*($clog2(MAX_BURST)+1)-1:0] blen,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      rvalid,
  output logic [IDX_W-1:0]          rvalid_id,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("mem_access_arbiter: unsupported NUM_REQ or MAX_BURST");
  end

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rvalid_q, rvalid_d;
  logic [IDX_W-1:0]   rvalid_id_q, rvalid_id_d;
  logic               access;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;

`ifdef MEM_ARB_BURST_EN
  localparam int BLEN_W = $clog2(MAX_BURST) + 1;
  logic [BLEN_W-1:0]  left_q, left_d;

  function automatic logic [BLEN_W-1:0] clamp_blen(input logic [BLEN_W-1:0] b);
    if (b == '0) return BLEN_W'(1);
    if (b > BLEN_W'(MAX_BURST)) return BLEN_W'(MAX_BURST);
    return b;
  endfunction
`endif

  assign access = (state_q == S_ACCESS);

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    rvalid_d    = access & ~we_q;
    rvalid_id_d = access ? win_q : rvalid_id_q;
`ifdef MEM_ARB_BURST_EN
    left_d      = left_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ACCESS;
          gnt_d   = NUM_REQ'(1) << pick;
          win_d   = pick;
          ptr_d   = (int'(pick) == NUM_REQ - 1) ? '0 : pick + IDX_W'(1);
          we_d    = we[pick];
          addr_d  = addr[pick*ADDR_W +: ADDR_W];
`ifdef MEM_ARB_BURST_EN
          left_d  = clamp_blen(blen[pick*BLEN_W +: BLEN_W]) - BLEN_W'(1);
`endif
        end
      end
      S_ACCESS: begin
`ifdef MEM_ARB_BURST_EN
        if (left_q == '0) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end else begin
          left_d  = left_q - BLEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
        end
`else
        state_d = S_IDLE;
        gnt_d   = '0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      win_q       <= '0;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      rvalid_q    <= 1'b0;
      rvalid_id_q <= '0;
`ifdef MEM_ARB_BURST_EN
      left_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      rvalid_q    <= rvalid_d;
      rvalid_id_q <= rvalid_id_d;
`ifdef MEM_ARB_BURST_EN
      left_q      <= left_d;
`endif
    end
  end

  // gnt_q is only non-zero in ACCESS, so it doubles as the per-beat ack.
  assign gnt       = gnt_q;
  assign ack       = gnt_q;
  assign mem_en    = access;
  assign mem_we    = access & we_q;
  assign mem_addr  = access ? addr_q : '0;
  assign mem_wdata = access ? wdata[win_q*DATA_W +: DATA_W] : '0;
  assign rvalid    = rvalid_q;
  assign rvalid_id = rvalid_id_q;
  assign rdata     = mem_rdata;

endmodule
